// File: rtl/rfphoenix_tlb_walker.sv
// rfphoenix_tlb_walker: two-level page-table walker and TLB write-port arbiter
//
// TLBE image layout (128 bits):
//   [0]       pte.v    valid
//   [5]       pte.m    modified, cleared on hardware refill
//   [63:32]   adr      address of the L2 entry the image came from
//   [82:64]   vpn      {va[31:23], 10'b0}
//   [105:96]  asid
// All other bits pass through from memory unchanged.
module rfphoenix_tlb_walker #(
    parameter int unsigned PTBR_ALIGN = 14,
    parameter logic [2:0]  WAY        = 3'd0,
    parameter int unsigned HOLDOFF    = 3
) (
    input  logic         clk_g,
    input  logic         rst_i,
    input  logic         walk_en_i,
    input  logic         miss_i,
    input  logic [31:0]  miss_adr_i,
    input  logic [9:0]   asid_i,
    input  logic [31:0]  ptbr_i,
    input  logic         abort_i,
    input  logic         sw_wr_i,
    input  logic [15:0]  sw_adr_i,
    input  logic [127:0] sw_dat_i,
    output logic         sw_ack_o,
    output logic         m_cyc_o,
    input  logic         m_ack_i,
    output logic [31:0]  m_adr_o,
    input  logic [127:0] m_dat_i,
    input  logic         tlb_rdy_i,
    output logic         wrtlb_o,
    output logic [15:0]  tlbadr_o,
    output logic [127:0] tlbdat_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         fault_o,
    output logic [31:0]  fault_adr_o
);
    localparam int PTE_V    = 0;
    localparam int PTE_M    = 5;
    localparam int ADR_LSB  = 32;
    localparam int VPN_LSB  = 64;
    localparam int ASID_LSB = 96;

    typedef enum logic [2:0] {IDLE, L1, L2, TLBWR, SWWR, HOLD} state_t;

    state_t         state;
    logic [31:0]    va;
    logic [7:0]     cnt;
    logic [127:0]   l2_ent;
    logic           wr_go;
    logic           unused_ptbr;

    assign unused_ptbr = &{1'b0, ptbr_i[PTBR_ALIGN-1:0]};

    // The write strobe is gated by tlb_rdy_i directly so it can never fire
    // while the TLB is busy, and fires in the very first ready cycle.
    assign wr_go    = tlb_rdy_i && !abort_i && (state == TLBWR || state == SWWR);
    assign wrtlb_o  = wr_go;
    assign done_o   = wr_go && state == TLBWR;
    assign sw_ack_o = wr_go && state == SWWR;
    assign busy_o   = state != IDLE;

    // Fetched L2 entry with the refill-owned fields replaced
    always_comb begin
        l2_ent                     = m_dat_i;
        l2_ent[PTE_M]              = 1'b0;
        l2_ent[ADR_LSB +: 32]      = m_adr_o;
        l2_ent[VPN_LSB +: 19]      = {va[31:23], 10'b0};
        l2_ent[ASID_LSB +: 10]     = asid_i;
    end

    // Walk state machine; memory-side outputs and TLB image are registered
    always_ff @(posedge clk_g or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            va          <= '0;
            cnt         <= '0;
            m_cyc_o     <= 1'b0;
            m_adr_o     <= '0;
            tlbadr_o    <= '0;
            tlbdat_o    <= '0;
            fault_o     <= 1'b0;
            fault_adr_o <= '0;
        end else begin
            fault_o <= 1'b0;
            if (abort_i) begin
                state   <= IDLE;
                m_cyc_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sw_wr_i) begin
                            tlbadr_o <= sw_adr_i;
                            tlbdat_o <= sw_dat_i;
                            state    <= SWWR;
                        end else if (miss_i && walk_en_i) begin
                            va      <= miss_adr_i;
                            m_adr_o <= {ptbr_i[31:PTBR_ALIGN], {PTBR_ALIGN{1'b0}}}
                                       + 32'({miss_adr_i[31:23], 4'h0});
                            m_cyc_o <= 1'b1;
                            state   <= L1;
                        end
                    end
                    L1: begin
                        if (m_ack_i && m_dat_i[PTE_V]) begin
                            m_adr_o <= {m_dat_i[31:PTBR_ALIGN], {PTBR_ALIGN{1'b0}}}
                                       + 32'({va[22:13], 4'h0});
                            state   <= L2;
                        end else if (m_ack_i) begin
                            m_cyc_o     <= 1'b0;
                            fault_o     <= 1'b1;
                            fault_adr_o <= va;
                            cnt         <= 8'(HOLDOFF - 1);
                            state       <= HOLD;
                        end
                    end
                    L2: begin
                        if (m_ack_i) begin
                            m_cyc_o  <= 1'b0;
                            tlbdat_o <= m_dat_i[PTE_V] ? l2_ent : m_dat_i;
                            tlbadr_o <= {1'b0, va[22:13], 2'b00, WAY};
                            fault_o     <= !m_dat_i[PTE_V];
                            fault_adr_o <= m_dat_i[PTE_V] ? fault_adr_o : va;
                            cnt         <= 8'(HOLDOFF - 1);
                            state       <= m_dat_i[PTE_V] ? TLBWR : HOLD;
                        end
                    end
                    TLBWR: begin
                        if (tlb_rdy_i) begin
                            cnt   <= 8'(HOLDOFF - 1);
                            state <= HOLD;
                        end
                    end
                    SWWR: begin
                        if (tlb_rdy_i)
                            state <= IDLE;
                    end
                    HOLD: begin
                        if (cnt == 8'd0)
                            state <= IDLE;
                        else
                            cnt <= cnt - 8'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rfphoenix_tlb_walker.sv
// tb_rfphoenix_tlb_walker: table-driven walks plus directed corner sequences
module tb_rfphoenix_tlb_walker;
    logic         clk_g = 1'b0;
    logic         rst_i = 1'b1;
    logic         walk_en_i = 1'b1;
    logic         miss_i = 1'b0;
    logic [31:0]  miss_adr_i = '0;
    logic [9:0]   asid_i = '0;
    logic [31:0]  ptbr_i = '0;
    logic         abort_i = 1'b0;
    logic         sw_wr_i = 1'b0;
    logic [15:0]  sw_adr_i = '0;
    logic [127:0] sw_dat_i = '0;
    logic         sw_ack_o;
    logic         m_cyc_o;
    logic         m_ack_i = 1'b0;
    logic [31:0]  m_adr_o;
    logic [127:0] m_dat_i = '0;
    logic         tlb_rdy_i = 1'b1;
    logic         wrtlb_o;
    logic [15:0]  tlbadr_o;
    logic [127:0] tlbdat_o;
    logic         busy_o;
    logic         done_o;
    logic         fault_o;
    logic [31:0]  fault_adr_o;

    int n_pass = 0;
    int n_total = 0;

    rfphoenix_tlb_walker dut (
        .clk_g(clk_g), .rst_i(rst_i), .walk_en_i(walk_en_i), .miss_i(miss_i),
        .miss_adr_i(miss_adr_i), .asid_i(asid_i), .ptbr_i(ptbr_i), .abort_i(abort_i),
        .sw_wr_i(sw_wr_i), .sw_adr_i(sw_adr_i), .sw_dat_i(sw_dat_i), .sw_ack_o(sw_ack_o),
        .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i), .m_adr_o(m_adr_o), .m_dat_i(m_dat_i),
        .tlb_rdy_i(tlb_rdy_i), .wrtlb_o(wrtlb_o), .tlbadr_o(tlbadr_o), .tlbdat_o(tlbdat_o),
        .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o), .fault_adr_o(fault_adr_o)
    );

    always #5 clk_g = ~clk_g;

    typedef struct {
        logic [31:0]  ptbr;
        logic [31:0]  va;
        logic [9:0]   asid;
        logic [31:0]  l1d;
        logic [127:0] l2d;
        logic [31:0]  l1a;
        logic [31:0]  l2a;
        int           flt;
        logic [15:0]  tadr;
        logic [127:0] tdat;
        int           waits;
    } vec_t;

    vec_t tv[4];

    task automatic step();
        @(posedge clk_g);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Drive a miss and act as memory up to the final ack (L1 ack on L1 fault)
    task automatic do_walk(input vec_t v);
        miss_adr_i = v.va;
        ptbr_i     = v.ptbr;
        asid_i     = v.asid;
        miss_i     = 1'b1;
        step();
        miss_i = 1'b0;
        chk("l1_cyc", m_cyc_o, 1);
        chk("l1_adr", m_adr_o, v.l1a);
        repeat (v.waits) step();
        chk("l1_adr_hold", m_adr_o, v.l1a);
        m_ack_i = 1'b1;
        m_dat_i = {96'h0, v.l1d};
        step();
        m_ack_i = 1'b0;
        if (v.flt != 1) begin
            chk("l2_cyc", m_cyc_o, 1);
            chk("l2_adr", m_adr_o, v.l2a);
            repeat (v.waits) step();
            m_ack_i = 1'b1;
            m_dat_i = v.l2d;
            step();
            m_ack_i = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        do_walk(v);
        chk("end_cyc", m_cyc_o, 0);
        chk("wrtlb", wrtlb_o, v.flt == 0);
        chk("done", done_o, v.flt == 0);
        chk("fault", fault_o, v.flt != 0);
        if (v.flt == 0) begin
            chk("tlbadr", tlbadr_o, v.tadr);
            chk("tlbdat", tlbdat_o, v.tdat);
        end else
            chk("fault_adr", fault_adr_o, v.va);
        step();
        chk("wrtlb_1cyc", wrtlb_o, 0);
        chk("done_1cyc", done_o, 0);
        chk("fault_1cyc", fault_o, 0);
        repeat (4) step();
        chk("idle_busy", busy_o, 0);
    endtask

    initial begin
        tv[0] = '{32'h0001_0000, 32'h1234_5678, 10'h155, 32'h0002_0001,
                  128'hABCD0000_00000000_00000000_00015421, 32'h0001_0240, 32'h0002_1A20,
                  0, 16'h3440, 128'hABCD0155_00009000_00021A20_00015401, 0};
        tv[1] = '{32'hFFFF_FFFF, 32'hFFFF_E000, 10'h3FF, 32'h8000_7FFF,
                  128'h00000000_00000000_FFFFFFFF_00000021, 32'hFFFF_DFF0, 32'h8000_7FF0,
                  0, 16'h7FE0, 128'h000003FF_0007FC00_80007FF0_00000001, 2};
        tv[2] = '{32'h0001_0000, 32'h1234_5678, 10'h0, 32'h0002_0000,
                  128'h0, 32'h0001_0240, 32'h0, 1, 16'h0, 128'h0, 1};
        tv[3] = '{32'h0004_0000, 32'h0080_2000, 10'h2A, 32'h0005_0001,
                  128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 32'h0004_0010, 32'h0005_0010,
                  2, 16'h0, 128'h0, 0};

        step();
        step();
        chk("rst_cyc", m_cyc_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_adr", m_adr_o, 0);
        chk("rst_fadr", fault_adr_o, 0);
        chk("rst_tadr", tlbadr_o, 0);
        chk("rst_wr", wrtlb_o, 0);
        rst_i = 1'b0;
        step();

        for (int i = 0; i < 4; i++) run_vec(tv[i]);

        // Miss held through the holdoff after a fault is only taken once IDLE
        do_walk(tv[2]);
        chk("hold_fault", fault_o, 1);
        miss_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_ignore", m_cyc_o, 0);
        end
        step();
        chk("hold_release", m_cyc_o, 1);
        miss_i  = 1'b0;
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_l1_cyc", m_cyc_o, 0);
        chk("abort_l1_busy", busy_o, 0);

        // TLB not ready for 10 cycles at the write
        tlb_rdy_i = 1'b0;
        do_walk(tv[0]);
        for (int i = 0; i < 10; i++) begin
            chk("rdy_wait_wr", wrtlb_o, 0);
            chk("rdy_wait_busy", busy_o, 1);
            if (i < 9) step();
        end
        tlb_rdy_i = 1'b1;
        #1;
        chk("rdy_wr", wrtlb_o, 1);
        chk("rdy_done", done_o, 1);
        chk("rdy_tdat", tlbdat_o, tv[0].tdat);
        step();
        chk("rdy_once", wrtlb_o, 0);
        repeat (4) step();

        // CSR write beats a simultaneous miss, walk follows
        sw_wr_i    = 1'b1;
        sw_adr_i   = 16'hBEEF;
        sw_dat_i   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        miss_adr_i = tv[0].va;
        ptbr_i     = tv[0].ptbr;
        miss_i     = 1'b1;
        step();
        chk("sw_ack", sw_ack_o, 1);
        chk("sw_wr", wrtlb_o, 1);
        chk("sw_adr", tlbadr_o, 16'hBEEF);
        chk("sw_dat", tlbdat_o, sw_dat_i);
        chk("sw_nocyc", m_cyc_o, 0);
        sw_wr_i = 1'b0;
        step();
        chk("sw_ack_1cyc", sw_ack_o, 0);
        chk("sw_idle_cyc", m_cyc_o, 0);
        step();
        miss_i = 1'b0;
        chk("sw_then_walk", m_cyc_o, 1);
        chk("sw_then_adr", m_adr_o, tv[0].l1a);

        // Abort in L2 with an ack in the same cycle
        m_ack_i = 1'b1;
        m_dat_i = {96'h0, tv[0].l1d};
        step();
        chk("ab_l2_adr", m_adr_o, tv[0].l2a);
        m_dat_i = tv[0].l2d;
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        m_ack_i = 1'b0;
        chk("ab_cyc", m_cyc_o, 0);
        chk("ab_busy", busy_o, 0);
        chk("ab_wr", wrtlb_o, 0);
        chk("ab_done", done_o, 0);
        chk("ab_fault", fault_o, 0);
        step();
        chk("ab_wr_after", wrtlb_o, 0);
        chk("ab_busy_after", busy_o, 0);

        // Walks disabled
        walk_en_i = 1'b0;
        miss_i    = 1'b1;
        step();
        step();
        chk("dis_cyc", m_cyc_o, 0);
        miss_i    = 1'b0;
        walk_en_i = 1'b1;
        step();

        // Asynchronous reset mid-L1
        miss_adr_i = tv[0].va;
        ptbr_i     = tv[0].ptbr;
        miss_i     = 1'b1;
        step();
        miss_i = 1'b0;
        chk("rst_l1_cyc", m_cyc_o, 1);
        #1 rst_i = 1'b1;
        #1;
        chk("rst_async_cyc", m_cyc_o, 0);
        chk("rst_async_busy", busy_o, 0);
        step();
        rst_i = 1'b0;
        step();
        run_vec(tv[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
